bin_to_bcd_seq: RTL

//  Sequential double-dabble converter: unsigned binary in, packed BCD digits out.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_add3.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the 7-segment stages.
// Holds nibble width, converter FSM states, digit sizing helper and segment codes.
package bcd_pkg;

    localparam int BCD_NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } b2b_state_t;

    // Smallest digit count d with 10**d >= 2**bin_w.
    function automatic int bcd_digits_needed(input int bin_w);
        longint unsigned pow2;
        longint unsigned p10;
        int              d;
        pow2 = 64'd1 << bin_w;
        p10  = 64'd1;
        d    = 0;
        for (int i = 0; i < 20; i++) begin
            if (p10 < pow2) begin
                p10 = p10 * 64'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

    // Active-high segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any nibble of 5 or more.
// Ports: i_nib = scratch nibble in, o_nib = corrected nibble out.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] i_nib,
    output logic [BCD_NIB_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one add-3/shift step per clock.
// Ports: clk, rst (sync high), start/bin in; busy, done pulse, packed bcd out.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_NIB_W*DIGITS-1:0] bcd
);

    localparam int SCR_W = BCD_NIB_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SR_W  = SCR_W + BIN_W;

    if (DIGITS < bcd_digits_needed(BIN_W)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    b2b_state_t       r_state;
    b2b_state_t       w_state_nxt;
    logic [BIN_W-1:0] r_bin;
    logic [SCR_W-1:0] r_scr;
    logic [CNT_W-1:0] r_cnt;
    logic [SCR_W-1:0] r_bcd;
    logic             r_done;
    logic [SCR_W-1:0] w_adj;
    logic [SR_W-1:0]  w_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_scr[g*BCD_NIB_W +: BCD_NIB_W]),
            .o_nib (w_adj[g*BCD_NIB_W +: BCD_NIB_W])
        );
    end

    // Corrected scratch and remaining binary shift together as one word.
    assign w_nxt  = {w_adj, r_bin} << 1;
    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_state_nxt = CONV;
            CONV:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == CONV);
        w_accept = (r_state == IDLE) && start;
        w_step   = (r_state == CONV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin <= bin;
                r_scr <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_scr <= w_nxt[SR_W-1:BIN_W];
                r_bin <= w_nxt[BIN_W-1:0];
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_bcd  <= w_nxt[SR_W-1:BIN_W];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
